fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised fetch stage with a prefetch instruction queue. Owns the PC and issues one request per cycle to a synchronous instruction memory. Buffers returned words with their PCs in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake. On a taken branch it redirects to branch_pc + pc_rel and flushes queued and in-flight fetches.

Parameters:
XLEN, 32, PC and address width
DEPTH, 4, queue entries (power of two, >= 2)
RESET_PC, 0, PC loaded on reset
PC_STEP, 1, PC increment per instruction (word-addressed memory)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request this cycle
imem_addr  out  XLEN  fetch address, valid while imem_req=1
imem_data  in  32  instruction word, valid exactly one cycle after the accepted request
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  32  head instruction
out_pc  out  XLEN  head PC
taken  in  1  branch redirect strobe, one cycle
branch_pc  in  XLEN  PC of the branch instruction
pc_rel  in  XLEN  signed offset, two's complement
count  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Clocking/reset: one clock (clk); reset synchronous, active-high, named reset.
- Reset values: fetch_pc=RESET_PC, imem_req=0, queue empty, count=0, out_valid=0, in-flight flag=0. out_instr and out_pc are 0 when empty.
- Issue rule: imem_req=1 iff !reset && !taken && (count + inflight - pop) < DEPTH.
  - pop = out_valid && out_ready.
  - imem_addr=fetch_pc.
  - On issue: fetch_pc <= fetch_pc + PC_STEP, inflight <= 1.
- Return: cycle after an issue, imem_data is pushed with its PC (captured at issue) unless squashed. Fetch-to-out_valid latency is 2 cycles on an empty queue.
- Credits: a request is never issued without a guaranteed free slot, so overflow cannot occur. Push and pop in the same cycle leave count unchanged.
- Handshake: out_instr and out_pc stay stable while out_valid=1 and out_ready=0. Head advances on pop.
- Redirect (taken=1 in cycle t):
  - fetch_pc <= branch_pc + pc_rel, mod 2^XLEN; wrap-around is silent.
  - Queue flushed: count=0 and out_valid=0 in t+1.
  - No request issued in t.
  - Response for a request issued in t-1 (arriving in t) is discarded.
  - First post-redirect request is in t+1 at the target address.
- Simultaneous events:
  - Pop in cycle t with taken=1 is a completed transfer; the flush still applies.
  - taken on consecutive cycles: the last one wins.
  - taken during reset is ignored.
- Reset mid-operation discards the queue and in-flight response. The response arriving the cycle after reset deasserts is not pushed.
- PC increment wraps modulo 2^XLEN.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched (32), perf_flushes (32) and perf_full_stalls (32). Counters are cleared by reset and saturate at all-ones.
  - perf_fetched increments per push.
  - perf_flushes increments per taken.
  - perf_full_stalls increments per cycle the issue rule blocks a request, excluding taken.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds the XLEN default, RESET_PC default, PC_STEP default and the queue entry layout {pc, instr}.
- Sub-module fetch_fifo: synchronous DEPTH x (XLEN+32) FIFO with push, pop, flush, count and head outputs, wrapping pointers.
- fetch_queue holds only PC, issue/credit, squash and redirect logic.

Test Plan:
- Reset then 6 cycles with out_ready=1, memory preloaded mem[i]=i+0x100 -> imem_addr 0,1,2,...; first out_valid 2 cycles after the first request, out_pc=0, out_instr=0x100, one instruction per cycle thereafter.
- out_ready=0 with DEPTH=4 -> exactly 4 requests (addr 0-3), then imem_req=0, count=4, head holds pc 0. Raise out_ready -> requests resume at addr 4 in the same cycle as the first pop.
- taken=1, branch_pc=2, pc_rel=0x1000 -> next cycle count=0, out_valid=0, imem_addr=0x1002. The stale word for the pre-redirect address is never presented.
- taken=1, branch_pc=0x1002, pc_rel=0xFFFFF000 -> fetch resumes at 0x2. Separately, branch_pc=0xFFFFFFFF, pc_rel=2 -> target 0x1 (wrap).
- reset asserted while count=3 with a request in flight -> next cycle count=0, out_valid=0, imem_addr=RESET_PC sequence restarts, no stale push.
- With FETCH_PERF_CNT_EN: 10 pushes, 2 taken, 5 full-stall cycles -> perf_fetched=10, perf_flushes=2, perf_full_stalls=5.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared defaults and queue entry layout for the fetch stage.
// Rev    : 1.0
// ============================================================================
package fetch_pkg;

    localparam int                     XLEN_DEF     = 32;
    localparam int                     INSTR_W      = 32;
    localparam logic [XLEN_DEF-1:0]    RESET_PC_DEF = '0;
    localparam int unsigned            PC_STEP_DEF  = 1;

    // Queue entry layout is {pc, instr}: instruction in the low bits.
    localparam int                     INSTR_LSB    = 0;
    localparam int                     PC_LSB       = INSTR_W;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Synchronous DEPTH x WIDTH FIFO with flush, occupancy and head view.
// Rev    : 1.0
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue
// Brief  : PC owner, credit-based instruction fetch and branch redirect.
//          Optional macro FETCH_PERF_CNT_EN adds saturating perf counters.
// Rev    : 1.0
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                XLEN     = XLEN_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  logic [31:0]          imem_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [XLEN-1:0]      out_pc,
    input  logic                 taken,
    input  logic [XLEN-1:0]      branch_pc,
    input  logic [XLEN-1:0]      pc_rel,
    output logic [$clog2(DEPTH):0] count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_flushes,
    output logic [31:0]          perf_full_stalls
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = CW + 1;
    localparam int EW = XLEN + INSTR_W;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic            pop;
    logic            push;
    logic            credit_ok;
    logic [NW-1:0]   need;
    logic [EW-1:0]   head_data;

    assign pop       = out_valid && out_ready;
    // Occupancy after this cycle if the in-flight word lands and the head leaves.
    assign need      = NW'(count) + NW'(inflight) - NW'(pop);
    assign credit_ok = (need < NW'(DEPTH));
    assign imem_req  = !reset && !taken && credit_ok;
    assign imem_addr = fetch_pc;
    assign push      = inflight && !taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight    <= imem_req;
            inflight_pc <= fetch_pc;
            if (taken) begin
                fetch_pc <= branch_pc + pc_rel;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ({inflight_pc, imem_data}),
        .pop        (pop),
        .flush      (taken),
        .count      (count),
        .head_valid (out_valid),
        .head_data  (head_data)
    );

    assign out_instr = head_data[INSTR_LSB +: INSTR_W];
    assign out_pc    = head_data[PC_LSB +: XLEN];

`ifdef FETCH_PERF_CNT_EN
    logic full_stall;

    assign full_stall = !reset && !taken && !credit_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched     <= '0;
            perf_flushes     <= '0;
            perf_full_stalls <= '0;
        end else begin
            if (push && perf_fetched != '1) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (taken && perf_flushes != '1) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
            if (full_stall && perf_full_stalls != '1) begin
                perf_full_stalls <= perf_full_stalls + 32'd1;
            end
        end
    end
`else
    // Counters are absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_queue
// Brief  : Directed self-checking bench for fetch_queue (mem[a] = a + 0x100).
// Rev    : 1.0
// ============================================================================
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        taken;
    logic [31:0] branch_pc;
    logic [31:0] pc_rel;
    logic [2:0]  count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
    logic [31:0] perf_full_stalls;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_data <= imem_addr + 32'h100;
    end

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .PC_STEP  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .taken     (taken),
        .branch_pc (branch_pc),
        .pc_rel    (pc_rel),
        .count     (count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_flushes     (perf_flushes),
        .perf_full_stalls (perf_full_stalls)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; taken = 1'b0; out_ready = 1'b0; branch_pc = '0; pc_rel = '0;
        next_cycle();
        next_cycle();
        sample();
        check("rst_req",   imem_req,  0);
        check("rst_count", count,     0);
        check("rst_valid", out_valid, 0);
        check("rst_instr", out_instr, 0);
        check("rst_pc",    out_pc,    0);
        next_cycle();

        // Streaming with decode always ready.
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            check("run_req",  imem_req,  1);
            check("run_addr", imem_addr, 32'(i));
            check("run_valid", out_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) begin
                check("run_pc",    out_pc,    32'(i - 2));
                check("run_instr", out_instr, 32'(i - 2) + 32'h100);
            end
            next_cycle();
        end

        // Back-pressure: fill the queue.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample();
            check("fill_req", imem_req, (i < 4) ? 1 : 0);
            if (i < 4) check("fill_addr", imem_addr, 32'(i));
            next_cycle();
        end
        // Six cycles in: queue full, nothing in flight.
        sample();
        check("full_count", count,     4);
        check("full_valid", out_valid, 1);
        check("full_pc",    out_pc,    0);
        check("full_instr", out_instr, 32'h100);
        check("full_req",   imem_req,  0);
        next_cycle();
        out_ready = 1'b1;
        sample();
        check("resume_req",  imem_req,  1);
        check("resume_addr", imem_addr, 32'h4);
        next_cycle();

        // Reset while count=3 with addr 4 in flight.
        out_ready = 1'b0; reset = 1'b1;
        sample();
        check("pre_rst_count", count,    3);
        check("pre_rst_pc",    out_pc,   1);
        check("in_rst_req",    imem_req, 0);
        next_cycle();
        reset = 1'b0; out_ready = 1'b1;
        sample();
        check("post_rst_count", count,     0);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_addr",  imem_addr, 0);
        check("post_rst_req",   imem_req,  1);
        next_cycle();
        sample();
        check("no_stale_count", count,     0);
        check("no_stale_valid", out_valid, 0);
        next_cycle();
        sample();
        check("restart_valid", out_valid, 1);
        check("restart_pc",    out_pc,    0);
        next_cycle();

        // Redirect forward.
        taken = 1'b1; branch_pc = 32'h2; pc_rel = 32'h1000;
        sample();
        check("br_valid", out_valid, 1);
        check("br_pc",    out_pc,    1);
        check("br_req",   imem_req,  0);
        next_cycle();
        taken = 1'b0;
        sample();
        check("br1_count", count,     0);
        check("br1_valid", out_valid, 0);
        check("br1_addr",  imem_addr, 32'h1002);
        check("br1_req",   imem_req,  1);
        next_cycle();
        sample();
        check("br2_valid", out_valid, 0);
        check("br2_count", count,     0);
        next_cycle();
        // Redirect backward while popping.
        taken = 1'b1; branch_pc = 32'h1002; pc_rel = 32'hFFFF_F000;
        sample();
        check("br3_valid", out_valid, 1);
        check("br3_pc",    out_pc,    32'h1002);
        check("br3_instr", out_instr, 32'h1102);
        check("br3_req",   imem_req,  0);
        next_cycle();
        taken = 1'b0;
        sample();
        check("neg_addr",  imem_addr, 32'h2);
        check("neg_valid", out_valid, 0);
        next_cycle();
        // Target wraps past 2^32.
        taken = 1'b1; branch_pc = 32'hFFFF_FFFF; pc_rel = 32'h2;
        next_cycle();
        // Back-to-back redirects: last one wins.
        branch_pc = 32'h40; pc_rel = 32'h10;
        sample();
        check("wrap_addr", imem_addr, 32'h1);
        check("wrap_req",  imem_req,  0);
        next_cycle();
        branch_pc = 32'h60; pc_rel = 32'h0;
        next_cycle();
        taken = 1'b0;
        sample();
        check("b2b_addr",  imem_addr, 32'h60);
        check("b2b_req",   imem_req,  1);
        check("b2b_count", count,     0);
        next_cycle();

`ifdef FETCH_PERF_CNT_EN
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; out_ready = 1'b0;
        sample();
        check("perf0_fetched", perf_fetched,     0);
        check("perf0_flushes", perf_flushes,     0);
        check("perf0_stalls",  perf_full_stalls, 0);
        // 4 requests then 5 full-stall cycles.
        for (int i = 0; i < 9; i++) next_cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) next_cycle();
        out_ready = 1'b0; taken = 1'b1; branch_pc = 32'h80; pc_rel = 32'h0;
        next_cycle();
        next_cycle();
        taken = 1'b0;
        sample();
        check("perf_fetched", perf_fetched,     10);
        check("perf_flushes", perf_flushes,     2);
        check("perf_stalls",  perf_full_stalls, 5);
        next_cycle();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
